// File: rtl/fmul_rr_scheduler.sv
// fmul_rr_scheduler: round-robin arbiter that shares one single-precision float
// multiplier among NREQ requesters. One operation is in flight at a time, and a
// forced low gap on mul_dataIn gives the multiplier a clean rising edge for every launch.
module fmul_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int GAP_CYC = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [32*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_prod,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 mul_dataIn,
    output logic [31:0]          mul_x,
    output logic [31:0]          mul_y,
    input  logic                 mul_dataOut,
    input  logic [31:0]          mul_prod
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_DONE,
        S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_win;
    logic [NREQ-1:0] r_gnt;
    logic [TW-1:0]   r_timer;
    logic [GW-1:0]   r_gapCnt;
    logic            r_mulDataIn;
    logic [31:0]     r_mulX;
    logic [31:0]     r_mulY;
    logic [31:0]     r_rspProd;
    logic            r_rspErr;

    logic            w_anyReq;
    logic [IW-1:0]   w_winIdx;
    logic [NREQ-1:0] w_winOneHot;
    logic [31:0]     w_winX;
    logic [31:0]     w_winY;
    logic [IW-1:0]   w_nextPtr;
    logic            w_timedOut;
    logic            w_gapDone;

    // Round-robin search: the requester closest to r_ptr (wrapping upward) wins.
    always_comb begin
        w_anyReq = 1'b0;
        w_winIdx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(r_ptr) + k) % NREQ]) begin
                w_anyReq = 1'b1;
                w_winIdx = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // Select the winner's operands and build its one-hot grant vector.
    always_comb begin
        w_winX      = '0;
        w_winY      = '0;
        w_winOneHot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winIdx == IW'(i)) begin
                w_winX         = req_x[32*i +: 32];
                w_winY         = req_y[32*i +: 32];
                w_winOneHot[i] = 1'b1;
            end
        end
    end

    assign w_nextPtr  = (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);
    assign w_timedOut = (r_timer == TW'(TIMEOUT));
    assign w_gapDone  = (r_gapCnt == GW'(GAP_CYC - 1));

    // State register; a low rstn abandons any operation in flight without a response.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; mul_dataOut is only looked at while waiting in RUN.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_anyReq) w_nextState = S_ISSUE;
            S_ISSUE: w_nextState = S_RUN;
            S_RUN:   if (mul_dataOut || w_timedOut) w_nextState = S_DONE;
            S_DONE:  w_nextState = S_GAP;
            S_GAP:   if (w_gapDone) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath: latch the winner, drive the multiplier, capture the result, rotate the pointer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr       <= '0;
            r_win       <= '0;
            r_gnt       <= '0;
            r_timer     <= '0;
            r_gapCnt    <= '0;
            r_mulDataIn <= 1'b0;
            r_mulX      <= '0;
            r_mulY      <= '0;
            r_rspProd   <= '0;
            r_rspErr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_win  <= w_winIdx;
                        r_gnt  <= w_winOneHot;
                        r_mulX <= w_winX;
                        r_mulY <= w_winY;
                    end
                end
                S_ISSUE: begin
                    r_mulDataIn <= 1'b1;
                    r_timer     <= '0;
                end
                S_RUN: begin
                    if (mul_dataOut) begin
                        r_rspProd <= mul_prod;
                        r_rspErr  <= 1'b0;
                    end else if (w_timedOut) begin
                        r_rspProd <= QNAN;
                        r_rspErr  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DONE: begin
                    r_mulDataIn <= 1'b0;
                    r_gnt       <= '0;
                    r_ptr       <= w_nextPtr;
                    r_gapCnt    <= '0;
                    r_rspErr    <= 1'b0;
                end
                S_GAP: begin
                    r_gapCnt <= r_gapCnt + GW'(1);
                end
                default: begin
                    r_mulDataIn <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign rsp_valid  = (r_state == S_DONE) ? r_gnt : '0;
    assign rsp_prod   = r_rspProd;
    assign rsp_err    = r_rspErr;
    assign busy       = (r_state != S_IDLE);
    assign mul_dataIn = r_mulDataIn;
    assign mul_x      = r_mulX;
    assign mul_y      = r_mulY;

endmodule

// File: tb/tb_fmul_rr_scheduler.sv
// tb_fmul_rr_scheduler: directed tests for the round-robin multiplier scheduler,
// with a behavioural multiplier that answers a fixed number of cycles after launch.
module tb_fmul_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int GAP_CYC = 2;
    localparam int TIMEOUT = 255;
    localparam int LMUL    = 6;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [32*NREQ-1:0]  reqX = '0;
    logic [32*NREQ-1:0]  reqY = '0;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     rspValid;
    logic [31:0]         rspProd;
    logic                rspErr;
    logic                busy;
    logic                mulDataIn;
    logic [31:0]         mulX;
    logic [31:0]         mulY;
    logic                mulDataOut;
    logic [31:0]         mulProd = '0;

    logic                modelOut = 1'b0;
    logic                forceOut = 1'b0;
    logic                neverDone = 1'b0;
    int                  mCnt = 0;

    int                  errors = 0;
    int                  checks = 0;

    fmul_rr_scheduler #(
        .NREQ(NREQ), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_x(reqX), .req_y(reqY),
        .gnt(gnt), .rsp_valid(rspValid), .rsp_prod(rspProd), .rsp_err(rspErr),
        .busy(busy), .mul_dataIn(mulDataIn), .mul_x(mulX), .mul_y(mulY),
        .mul_dataOut(mulDataOut), .mul_prod(mulProd)
    );

    always #5 clk = ~clk;

    assign mulDataOut = modelOut | forceOut;

    // Products for the operand pairs used here: 1.0*y = y, 1.5*2.0, -2.0*2.0.
    function automatic logic [31:0] fmulTable(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000) return b;
        if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'hC000_0000 && b == 32'h4000_0000) return 32'hC080_0000;
        return 32'hFFFF_FFFF;
    endfunction

    // Multiplier model: result-ready goes high LMUL cycles after mul_dataIn rises.
    always @(negedge clk) begin
        if (mulDataIn) begin
            mCnt     = mCnt + 1;
            mulProd  = fmulTable(mulX, mulY);
            modelOut = (mCnt > LMUL) && !neverDone;
        end else begin
            mCnt     = 0;
            modelOut = 1'b0;
        end
    end

    task automatic setOperands(input int idx, input logic [31:0] x, input logic [31:0] y);
        reqX[32*idx +: 32] = x;
        reqY[32*idx +: 32] = y;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic waitRsp(input int limit, output int k, output bit seen);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < limit) begin
            @(negedge clk);
            k++;
            if (rspValid != '0) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req  = '0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt got=%b want=0000", gnt); end
        checks++; if (rspValid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rspValid got=%b want=0000", rspValid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (mulDataIn !== 1'b0) begin errors++; $display("[TB] FAIL reset_mulDataIn got=%b want=0", mulDataIn); end
        checks++; if ({mulX, mulY} !== 64'h0) begin errors++; $display("[TB] FAIL reset_operands got=%h want=0", {mulX, mulY}); end
        checks++; if ({rspProd, rspErr} !== 33'h0) begin errors++; $display("[TB] FAIL reset_rsp got=%h want=0", {rspProd, rspErr}); end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        int firstK = 0;
        int rspCount = 0;
        int gntCycles = 0;
        logic [NREQ-1:0] vAt = '0;
        logic [31:0] prodAt = '0;
        logic errAt = 1'b1;
        logic [31:0] xRun = '0;
        logic dinRun = 1'b0;
        logic busyGap = 1'b0;
        logic busyIdle = 1'b1;
        setOperands(0, 32'h3F80_0000, 32'h4000_0000);
        req = 4'b0001;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (gnt == 4'b0001) gntCycles++;
            else if (gnt != 4'b0000) gntCycles += 100;
            if (rspValid != '0) begin
                rspCount++;
                if (firstK == 0) begin
                    firstK = k; vAt = rspValid; prodAt = rspProd; errAt = rspErr;
                    req = '0;
                end
            end
            if (k == 3) begin xRun = mulX; dinRun = mulDataIn; end
            if (k == 11) busyGap = busy;
            if (k == 12) busyIdle = busy;
        end
        checks++; if (firstK != LMUL + 3) begin errors++; $display("[TB] FAIL single_latency got=%0d want=%0d", firstK, LMUL + 3); end
        checks++; if (rspCount != 1) begin errors++; $display("[TB] FAIL single_rspCount got=%0d want=1", rspCount); end
        checks++; if (vAt !== 4'b0001) begin errors++; $display("[TB] FAIL single_rspValid got=%b want=0001", vAt); end
        checks++; if (prodAt !== 32'h4000_0000) begin errors++; $display("[TB] FAIL single_prod got=%h want=40000000", prodAt); end
        checks++; if (errAt !== 1'b0) begin errors++; $display("[TB] FAIL single_err got=%b want=0", errAt); end
        checks++; if (gntCycles != LMUL + 3) begin errors++; $display("[TB] FAIL single_gntCycles got=%0d want=%0d", gntCycles, LMUL + 3); end
        checks++; if ({xRun, dinRun} !== {32'h3F80_0000, 1'b1}) begin errors++; $display("[TB] FAIL single_mulDrive got=%h/%b want=3f800000/1", xRun, dinRun); end
        checks++; if ({busyGap, busyIdle} !== 2'b10) begin errors++; $display("[TB] FAIL single_busyTail got=%b want=10", {busyGap, busyIdle}); end
    endtask

    task automatic test_pair();
        int nRsp = 0;
        int rspK[2] = '{0, 0};
        logic [NREQ-1:0] rspV[2] = '{4'b0, 4'b0};
        logic [31:0] rspP[2] = '{32'h0, 32'h0};
        int gapCycles = 0;
        int dinInGap = 0;
        doReset();
        setOperands(1, 32'h3FC0_0000, 32'h4000_0000);
        setOperands(2, 32'hC000_0000, 32'h4000_0000);
        req = 4'b0110;
        for (int k = 1; k <= 40 && nRsp < 2; k++) begin
            @(negedge clk);
            if (rspValid != '0) begin
                rspK[nRsp] = k; rspV[nRsp] = rspValid; rspP[nRsp] = rspProd;
                nRsp++;
                req = req & ~rspValid;
            end else if (nRsp == 1 && busy && gnt == '0) begin
                gapCycles++;
                if (mulDataIn) dinInGap++;
            end
        end
        checks++; if (rspK[0] != LMUL + 3) begin errors++; $display("[TB] FAIL pair_firstK got=%0d want=%0d", rspK[0], LMUL + 3); end
        checks++; if (rspV[0] !== 4'b0010) begin errors++; $display("[TB] FAIL pair_firstWinner got=%b want=0010", rspV[0]); end
        checks++; if (rspP[0] !== 32'h4040_0000) begin errors++; $display("[TB] FAIL pair_firstProd got=%h want=40400000", rspP[0]); end
        checks++; if (rspK[1] != 2 * LMUL + 9) begin errors++; $display("[TB] FAIL pair_secondK got=%0d want=%0d", rspK[1], 2 * LMUL + 9); end
        checks++; if (rspV[1] !== 4'b0100) begin errors++; $display("[TB] FAIL pair_secondWinner got=%b want=0100", rspV[1]); end
        checks++; if (rspP[1] !== 32'hC080_0000) begin errors++; $display("[TB] FAIL pair_secondProd got=%h want=c0800000", rspP[1]); end
        checks++; if (gapCycles != GAP_CYC) begin errors++; $display("[TB] FAIL pair_gapCycles got=%0d want=%0d", gapCycles, GAP_CYC); end
        checks++; if (dinInGap != 0) begin errors++; $display("[TB] FAIL pair_dataInLowInGap got=%0d want=0", dinInGap); end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] yTab[4] = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
        int nOps = 0;
        int oneHotBad = 0;
        logic [NREQ-1:0] wantV;
        doReset();
        for (int i = 0; i < NREQ; i++) setOperands(i, 32'h3F80_0000, yTab[i]);
        req = 4'b1111;
        for (int k = 1; k <= 200 && nOps < 8; k++) begin
            @(negedge clk);
            if (gnt != '0 && !$onehot(gnt)) oneHotBad++;
            if (rspValid != '0) begin
                wantV = 4'b0001 << (nOps % NREQ);
                checks++; if (rspValid !== wantV) begin errors++; $display("[TB] FAIL rr_grant%0d got=%b want=%b", nOps, rspValid, wantV); end
                checks++; if (rspProd !== yTab[nOps % NREQ]) begin errors++; $display("[TB] FAIL rr_prod%0d got=%h want=%h", nOps, rspProd, yTab[nOps % NREQ]); end
                nOps++;
            end
        end
        req = '0;
        checks++; if (nOps != 8) begin errors++; $display("[TB] FAIL rr_opCount got=%0d want=8", nOps); end
        checks++; if (oneHotBad != 0) begin errors++; $display("[TB] FAIL rr_oneHot got=%0d want=0", oneHotBad); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_timeout();
        int k;
        bit seen;
        neverDone = 1'b1;
        setOperands(0, 32'h3F80_0000, 32'h4000_0000);
        req = 4'b0001;
        waitRsp(400, k, seen);
        checks++; if (!seen || k != TIMEOUT + 3) begin errors++; $display("[TB] FAIL timeout_latency got=%0d seen=%0b want=%0d", k, seen, TIMEOUT + 3); end
        checks++; if (rspValid !== 4'b0001) begin errors++; $display("[TB] FAIL timeout_rspValid got=%b want=0001", rspValid); end
        checks++; if (rspProd !== 32'h7FC0_0000) begin errors++; $display("[TB] FAIL timeout_prod got=%h want=7fc00000", rspProd); end
        checks++; if (rspErr !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err got=%b want=1", rspErr); end
        req = '0;
        neverDone = 1'b0;
        repeat (4) @(negedge clk);
        setOperands(1, 32'h3FC0_0000, 32'h4000_0000);
        req = 4'b0010;
        waitRsp(40, k, seen);
        checks++; if (!seen || k != LMUL + 3) begin errors++; $display("[TB] FAIL afterTimeout_latency got=%0d want=%0d", k, LMUL + 3); end
        checks++; if ({rspValid, rspProd, rspErr} !== {4'b0010, 32'h4040_0000, 1'b0}) begin
            errors++; $display("[TB] FAIL afterTimeout_rsp got=%b/%h/%b want=0010/40400000/0", rspValid, rspProd, rspErr);
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int k;
        bit seen;
        setOperands(3, 32'h3F80_0000, 32'h40A0_0000);
        req = 4'b1000;
        repeat (4) @(negedge clk);
        checks++; if ({busy, gnt, mulDataIn} !== {1'b1, 4'b1000, 1'b1}) begin
            errors++; $display("[TB] FAIL midrun_pre got=%b/%b/%b want=1/1000/1", busy, gnt, mulDataIn);
        end
        rstn = 1'b0;
        @(negedge clk);
        checks++; if ({gnt, rspValid, busy, mulDataIn} !== 10'b0) begin
            errors++; $display("[TB] FAIL midrun_ctrl got=%b/%b/%b/%b want=0", gnt, rspValid, busy, mulDataIn);
        end
        checks++; if ({mulX, mulY, rspProd, rspErr} !== 97'h0) begin
            errors++; $display("[TB] FAIL midrun_data got=%h/%h/%h/%b want=0", mulX, mulY, rspProd, rspErr);
        end
        rstn = 1'b1;
        waitRsp(40, k, seen);
        checks++; if (!seen || k != LMUL + 3) begin errors++; $display("[TB] FAIL midrun_regrantLatency got=%0d want=%0d", k, LMUL + 3); end
        checks++; if ({rspValid, rspProd} !== {4'b1000, 32'h40A0_0000}) begin
            errors++; $display("[TB] FAIL midrun_regrant got=%b/%h want=1000/40a00000", rspValid, rspProd);
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_glitch();
        int k;
        bit seen;
        int bad = 0;
        int spurious = 0;
        forceOut = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rspValid != '0 || busy) bad++;
        end
        forceOut = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL glitch_idle got=%0d want=0", bad); end
        setOperands(0, 32'h3F80_0000, 32'h4000_0000);
        req = 4'b0001;
        waitRsp(40, k, seen);
        checks++; if (!seen || rspProd !== 32'h4000_0000) begin errors++; $display("[TB] FAIL glitch_op got=%h seen=%0b want=40000000", rspProd, seen); end
        req = '0;
        forceOut = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rspValid != '0) spurious++;
        end
        checks++; if (spurious != 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_gap got=%0d/%b want=0/0", spurious, busy); end
        forceOut = 1'b0;
        setOperands(1, 32'h3F80_0000, 32'h4040_0000);
        req = 4'b0010;
        waitRsp(40, k, seen);
        checks++; if (!seen || k != LMUL + 3 || rspProd !== 32'h4040_0000) begin
            errors++; $display("[TB] FAIL glitch_recover got=%0d/%h want=%0d/40400000", k, rspProd, LMUL + 3);
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
